// File: rtl/shift_pkg.sv
// Shared definitions for the 8-bit logical shifter family.
// Holds the direction encoding and the decoder FSM states.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/shift_decoder_cand.sv
// Candidate generator: logical zero-fill shift of din by n in direction dir.
// Shared between the decoder and the shifter reference model.
module shift_cand
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [NW-1:0]    n,
  input  logic             dir,
  output logic [WIDTH-1:0] shifted
);

  // Select the shift direction for the current candidate
  always_comb begin
    shifted = {WIDTH{1'b0}};
    if (dir == DIR_RIGHT) begin
      shifted = din >> n;
    end else begin
      shifted = din << n;
    end
  end

endmodule

// File: rtl/shift_decoder.sv
// Recovers (n, dir) mapping din to dshift by testing one candidate per clock,
// lowest index first, and returns the first match or a not-found flag.
module shift_decoder
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dshift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_found,
  output logic [NW-1:0]    out_n,
  output logic             out_dir
);

  // WIDTH is a power of two, so the last candidate index is all ones
  localparam logic [NW:0] K_LAST = {(NW+1){1'b1}};
  localparam logic [NW:0] K_ONE  = {{NW{1'b0}}, 1'b1};

  state_t           state_r;
  logic [NW:0]      k_r;
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] dshift_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_found_r;
  logic [NW-1:0]    out_n_r;
  logic             out_dir_r;

  logic [NW-1:0]    cand_n_s;
  logic             cand_dir_s;
  logic [WIDTH-1:0] cand_word_s;
  logic             match_s;

  assign cand_n_s   = k_r[NW:1];
  assign cand_dir_s = k_r[0];
  assign match_s    = (cand_word_s == dshift_r);

  shift_cand #(.WIDTH(WIDTH), .NW(NW)) u_cand (
    .din     (din_r),
    .n       (cand_n_s),
    .dir     (cand_dir_s),
    .shifted (cand_word_s)
  );

  // Handshake FSM, candidate index and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= {(NW+1){1'b0}};
      din_r       <= {WIDTH{1'b0}};
      dshift_r    <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_found_r <= 1'b0;
      out_n_r     <= {NW{1'b0}};
      out_dir_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            din_r      <= din;
            dshift_r   <= dshift;
            k_r        <= {(NW+1){1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= SEARCH;
          end
        end
        SEARCH: begin
          if (match_s) begin
            out_n_r     <= cand_n_s;
            out_dir_r   <= cand_dir_s;
            out_found_r <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (k_r == K_LAST) begin
            out_n_r     <= {NW{1'b0}};
            out_dir_r   <= DIR_LEFT;
            out_found_r <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_found = out_found_r;
  assign out_n     = out_n_r;
  assign out_dir   = out_dir_r;

endmodule

// File: tb/tb_shift_decoder.sv
// Directed self-checking bench for shift_decoder.
module tb_shift_decoder;

  localparam int WIDTH = 8;
  localparam int NW    = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dshift;
  logic             out_valid;
  logic             out_ready;
  logic             out_found;
  logic [NW-1:0]    out_n;
  logic             out_dir;

  int checks = 0;
  int errors = 0;

  shift_decoder #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .dshift    (dshift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_n     (out_n),
    .out_dir   (out_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a pair at E0, then count edges until out_valid (bounded).
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, output int cyc);
    din = a; dshift = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; din = 8'h00; dshift = 8'h00;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = 8'h00; dshift = 8'h00;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_found !== 1'b0 || out_n !== 3'd0 || out_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b fnd=%b n=%0d dir=%b, want 1 0 0 0 0", in_ready, out_valid, out_found, out_n, out_dir);
    end
  endtask

  // Run one transaction with out_ready=1 and check result, latency and return to IDLE.
  task automatic test_case(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic ef, input logic [2:0] en, input logic ed, input int elat);
    int cyc;
    out_ready = 1'b1;
    start_and_wait(a, b, cyc);
    checks++;
    if (cyc !== elat) begin
      errors++;
      $display("FAIL %s latency: got E%0d want E%0d", name, cyc, elat);
    end
    checks++;
    if (out_found !== ef || out_n !== en || out_dir !== ed) begin
      errors++;
      $display("FAIL %s result: found=%b n=%0d dir=%b want found=%b n=%0d dir=%b", name, out_found, out_n, out_dir, ef, en, ed);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready in DONE: got %b want 0", name, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: vld=%b rdy=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    start_and_wait(8'b10101001, 8'b00101010, cyc);
    checks++;
    if (cyc !== 6 || out_found !== 1'b1 || out_n !== 3'd2 || out_dir !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: lat=%0d found=%b n=%0d dir=%b want 6 1 2 1", cyc, out_found, out_n, out_dir);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      din = 8'h5A; dshift = 8'h5A;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_found !== 1'b1 || out_n !== 3'd2 || out_dir !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b found=%b n=%0d dir=%b want 1 0 1 2 1", i, out_valid, in_ready, out_found, out_n, out_dir);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_search();
    int seen;
    out_ready = 1'b1;
    din = 8'h01; dshift = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_found !== 1'b0 || out_n !== 3'd0 || out_dir !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b fnd=%b n=%0d dir=%b want 1 0 0 0 0", in_ready, out_valid, out_found, out_n, out_dir);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_silent: out_valid seen %0d cycles want 0", seen);
    end
    test_case("after_reset", 8'h5A, 8'h5A, 1'b1, 3'd0, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_case("right", 8'b10101001, 8'b00101010, 1'b1, 3'd2, 1'b1, 6);
    test_case("left",  8'b10110101, 8'b10101000, 1'b1, 3'd3, 1'b0, 7);
    test_case("nomatch", 8'h01, 8'h03, 1'b0, 3'd0, 1'b0, 16);
    test_case("f0_zero", 8'hF0, 8'h00, 1'b1, 3'd4, 1'b0, 9);
    test_case("identity", 8'h5A, 8'h5A, 1'b1, 3'd0, 1'b0, 1);
    test_case("zero_zero", 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1);
    test_case("msb_right", 8'h80, 8'h01, 1'b1, 3'd7, 1'b1, 16);
    test_backpressure();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_decoder.md
# shift_decoder

Recovers the shift amount and direction that map an original word to a shifted word. It is the inverse companion of the team's 8-bit logical shifter and is used to check or decode shifter traffic in-system. The block accepts a word pair over a valid/ready handshake and searches one candidate (n, dir) per clock. It returns the first match, or a not-found flag, over a second valid/ready handshake.

## Interface
- WIDTH, 8, data word width (power of two, ≥2)
- NW, $clog2(WIDTH), width of shift-amount field
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  word pair offered
- in_ready  output  1  block can accept a pair (high only in IDLE)
- din  input  WIDTH  original word
- dshift  input  WIDTH  shifted word to decode
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_found  output  1  a matching (n, dir) exists
- out_n  output  NW  decoded shift amount
- out_dir  output  1  decoded direction: 0 = left (toward MSB), 1 = right (toward LSB)

## Operation
- Shifts are logical, zero-fill, with amount 0..WIDTH-1, matching the shifter.
- There are 2*WIDTH candidates, indexed k = 0..2*WIDTH-1. For each k, n = k[NW:1] and dir = k[0]. Search order is therefore n0L, n0R, n1L, n1R, and so on.
- A candidate matches when (dir ? din >> n : din << n) == dshift.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, register din and dshift, clear k, and go to SEARCH.
  - SEARCH: compare candidate k.
    - On a match, latch out_n=n, out_dir=dir, out_found=1, and go to DONE.
    - Else, if k == 2*WIDTH-1, latch out_n=0, out_dir=0, out_found=0, and go to DONE.
    - Else, increment k.
  - DONE: out_valid=1 and outputs held stable. When out_ready is high, go to IDLE.
- Ambiguous pairs return the lowest k. Consequently:
  - din == dshift always gives n=0, dir=0.
  - din=0 with dshift=0 gives n=0, dir=0, found=1.
- Inputs din and dshift are ignored outside the IDLE accept cycle.
- in_valid held high while not in IDLE has no effect.

## Timing
- Reset values: state IDLE, out_valid=0, out_found=0, out_n=0, out_dir=0, k=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-SEARCH or in DONE abandons the transaction with no result emitted. The block returns to IDLE on the next edge.
- Let the accept edge be E0. A match at index k raises out_valid after edge E(k+1).
  - The not-found result also appears after edge E(2*WIDTH).
- out_valid falls on the edge where out_ready is sampled high. in_ready rises on that same edge.
- Minimum transaction period is 3 cycles (accept, one search cycle, DONE with out_ready=1).
- Back-to-back transactions are not overlapped.
- out_ready low holds DONE indefinitely; all outputs stay stable.

## Structure
- Package shift_pkg holds:
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1, shared with the shifter.
  - The FSM state enum (IDLE, SEARCH, DONE).
- Optional combinational sub-module shift_cand(din, n, dir) -> shifted word. It is reused by the shifter's reference model in the bench.
- All registers are in a single clocked process. The candidate compare is combinational.

## Test plan
- Right shift: din=8'b10101001, dshift=8'b00101010, out_ready=1. Required: found=1, n=2, dir=1 (k=5), out_valid after E6.
- Left shift: din=8'b10110101, dshift=8'b10101000. Required: found=1, n=3, dir=0 (k=6), out_valid after E7.
- No match: din=8'h01, dshift=8'h03. Required: found=0, n=0, dir=0, out_valid after E16.
- Ambiguity and zero cases:
  - din=8'hF0, dshift=8'h00 gives found=1, n=4, dir=0.
  - din=dshift=8'h5A gives found=1, n=0, dir=0 after E1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: outputs stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 drops out_valid and raises in_ready on the same edge.
- Reset mid-search: assert rst at k=3 of the no-match case. Required: out_valid never asserts, and all outputs take reset values. A fresh pair is then accepted normally.
